// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider (DIV/DIVU) feeding HI/LO; result = {remainder, quotient}.
// Optional macro DIV_ZERO_FAST_EN: zero divisor completes in one cycle through BY_ZERO.
module div_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        signed_div_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  input  logic        start_i,
  input  logic        annul_i,
  output logic [63:0] result_o,
  output logic        ready_o,
  output logic        busy_o
);

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {FREE, BY_ZERO, ON, END} state_t;

  state_t              state, state_nxt;
  logic [4:0]          cnt;
  logic [DATA_W-1:0]   dvd_orig;
  logic [DATA_W-1:0]   dvs_mag;
  logic [DATA_W-1:0]   rem;
  logic [DATA_W-1:0]   quo;
  logic                neg_q;
  logic                neg_r;
`ifndef DIV_ZERO_FAST_EN
  logic                zero_dvs;
`endif
  logic [2*DATA_W-1:0] result_q;

  logic                accept;
  logic                last;
  logic [DATA_W:0]     partial;
  logic [DATA_W:0]     diff;
  logic                ge;
  logic [DATA_W-1:0]   rem_nxt;
  logic [DATA_W-1:0]   quo_nxt;
  logic [2*DATA_W-1:0] result_fin;

  function automatic logic [DATA_W-1:0] mag(input logic sgn, input logic signed [DATA_W-1:0] x);
    return (sgn && x[DATA_W-1]) ? DATA_W'(~x + 1'b1) : x;
  endfunction

  function automatic logic [DATA_W-1:0] apply_sign(input logic neg, input logic [DATA_W-1:0] x);
    return neg ? DATA_W'(~x + 1'b1) : x;
  endfunction

  assign accept = start_i && !annul_i;
  assign last   = (cnt == 5'd31);

  // One restoring step: shift the next dividend bit into the remainder, trial-subtract
  always_comb begin
    partial = {rem, quo[DATA_W-1]};
    diff    = partial - {1'b0, dvs_mag};
    ge      = ~diff[DATA_W];
    rem_nxt = ge ? diff[DATA_W-1:0] : partial[DATA_W-1:0];
    quo_nxt = {quo[DATA_W-2:0], ge};
  end

  always_comb begin
    result_fin = {apply_sign(neg_r, rem_nxt), apply_sign(neg_q, quo_nxt)};
`ifndef DIV_ZERO_FAST_EN
    if (zero_dvs)
      result_fin = {dvd_orig, {DATA_W{1'b1}}};
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FREE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (state == FREE && accept)
        cnt <= '0;
      else if (state == ON)
        cnt <= cnt + 5'd1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      FREE: begin
        if (accept) begin
`ifdef DIV_ZERO_FAST_EN
          state_nxt = (opdata2_i == '0) ? BY_ZERO : ON;
`else
          state_nxt = ON;
`endif
        end
      end
      BY_ZERO: state_nxt = annul_i ? FREE : END;
      ON: begin
        if (annul_i)
          state_nxt = FREE;
        else if (last)
          state_nxt = END;
      end
      END:     state_nxt = start_i ? END : FREE;
      default: state_nxt = FREE;
    endcase
  end

  always_comb begin
    ready_o  = (state == END);
    busy_o   = (state != FREE);
    result_o = ready_o ? result_q : '0;
  end

  // Operand capture and iteration datapath; held data needs no reset since outputs are gated
  always_ff @(posedge clk) begin
    case (state)
      FREE: begin
        if (accept) begin
          dvd_orig <= opdata1_i;
          dvs_mag  <= mag(signed_div_i, opdata2_i);
          quo      <= mag(signed_div_i, opdata1_i);
          rem      <= '0;
          neg_q    <= signed_div_i & (opdata1_i[DATA_W-1] ^ opdata2_i[DATA_W-1]);
          neg_r    <= signed_div_i & opdata1_i[DATA_W-1];
`ifndef DIV_ZERO_FAST_EN
          zero_dvs <= (opdata2_i == '0);
`endif
        end
      end
      ON: begin
        rem <= rem_nxt;
        quo <= quo_nxt;
        if (last)
          result_q <= result_fin;
      end
      BY_ZERO: result_q <= {dvd_orig, {DATA_W{1'b1}}};
      default: ;
    endcase
  end

endmodule

// File: tb/tb_div_unit.sv
// Bench for div_unit: table of divide vectors through a scoreboard, plus annul and reset corner cases.
module tb_div_unit;

  logic        clk;
  logic        rst;
  logic        signed_div;
  logic [31:0] opdata1;
  logic [31:0] opdata2;
  logic        start;
  logic        annul;
  logic [63:0] result;
  logic        ready;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;

  logic [63:0] sb_q[$];

  typedef struct {
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  div_unit dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div),
    .opdata1_i    (opdata1),
    .opdata2_i    (opdata2),
    .start_i      (start),
    .annul_i      (annul),
    .result_o     (result),
    .ready_o      (ready),
    .busy_o       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, exp);
    end
  endtask

  task automatic run_op(input string name, input logic sgn, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] exp);
    int cyc;
    int exp_lat;
    logic [63:0] want;
    exp_lat = 32;
`ifdef DIV_ZERO_FAST_EN
    if (b == 32'd0) exp_lat = 1;
`endif
    @(negedge clk);
    signed_div = sgn;
    opdata1    = a;
    opdata2    = b;
    start      = 1'b1;
    sb_q.push_back(exp);
    @(posedge clk);
    #1;
    opdata1    = $urandom;
    opdata2    = $urandom;
    signed_div = ~sgn;
    for (cyc = 1; cyc <= 40; cyc++) begin
      @(posedge clk);
      #1;
      if (cyc == 1) check({name, " busy"}, 64'(busy), 64'd1);
      if (ready) break;
    end
    check({name, " latency"}, 64'(cyc), 64'(exp_lat));
    if (sb_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s scoreboard: empty queue at result", name);
    end else begin
      want = sb_q.pop_front();
      if (ready) check({name, " result"}, result, want);
    end
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #1;
    check({name, " ready drop"}, 64'(ready), 64'd0);
    check({name, " result clr"}, result, 64'd0);
  endtask

  vec_t vecs[11];

  initial begin
    vecs[0]  = '{1'b0, 32'd100,        32'd7,          32'h00000002, 32'h0000000E};
    vecs[1]  = '{1'b1, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[2]  = '{1'b1, 32'd7,          32'hFFFFFFFE,   32'h00000001, 32'hFFFFFFFD};
    vecs[3]  = '{1'b1, 32'h80000000,   32'hFFFFFFFF,   32'h00000000, 32'h80000000};
    vecs[4]  = '{1'b0, 32'h80000000,   32'hFFFFFFFF,   32'h80000000, 32'h00000000};
    vecs[5]  = '{1'b0, 32'h00001234,   32'd0,          32'h00001234, 32'hFFFFFFFF};
    vecs[6]  = '{1'b1, 32'hFFFFFF00,   32'd0,          32'hFFFFFF00, 32'hFFFFFFFF};
    vecs[7]  = '{1'b1, 32'hFFFFFF9C,   32'hFFFFFFF9,   32'hFFFFFFFE, 32'h0000000E};
    vecs[8]  = '{1'b0, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'h00000000, 32'h00000001};
    vecs[9]  = '{1'b0, 32'd5,          32'd10,         32'h00000005, 32'h00000000};
    vecs[10] = '{1'b0, 32'hFFFFFFFF,   32'd1,          32'h00000000, 32'hFFFFFFFF};

    rst        = 1'b1;
    signed_div = 1'b0;
    opdata1    = '0;
    opdata2    = '0;
    start      = 1'b0;
    annul      = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset ready", 64'(ready), 64'd0);
    check("reset busy", 64'(busy), 64'd0);
    check("reset result", result, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 11; i++)
      run_op($sformatf("vec%0d", i), vecs[i].sgn, vecs[i].a, vecs[i].b, {vecs[i].hi, vecs[i].lo});

    // Annul on the 10th iteration edge
    @(negedge clk);
    signed_div = 1'b0;
    opdata1    = 32'd1000;
    opdata2    = 32'd3;
    start      = 1'b1;
    @(posedge clk);
    repeat (9) @(posedge clk);
    @(negedge clk);
    annul = 1'b1;
    start = 1'b0;
    @(posedge clk);
    #1;
    check("annul busy", 64'(busy), 64'd0);
    check("annul ready", 64'(ready), 64'd0);
    @(negedge clk);
    annul = 1'b0;
    begin
      logic seen = 1'b0;
      repeat (30) begin
        @(posedge clk);
        #1;
        if (ready) seen = 1'b1;
      end
      check("annul no ready", 64'(seen), 64'd0);
    end
    run_op("post annul", 1'b0, 32'd50, 32'd5, {32'd0, 32'd10});

    // Reset on the 20th iteration edge
    @(negedge clk);
    signed_div = 1'b1;
    opdata1    = 32'd12345;
    opdata2    = 32'd67;
    start      = 1'b1;
    @(posedge clk);
    repeat (19) @(posedge clk);
    @(negedge clk);
    rst   = 1'b1;
    start = 1'b0;
    @(posedge clk);
    #1;
    check("midrst busy", 64'(busy), 64'd0);
    check("midrst ready", 64'(ready), 64'd0);
    check("midrst result", result, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    run_op("post rst", 1'b1, 32'd12345, 32'hFFFFFFBD, {32'd17, 32'hFFFFFF48});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
